// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
//   Shared definitions for the stepper-motor sequencer:
//     - state_t      : sequencer FSM states
//     - PHASE_TABLE  : 8-entry coil pattern table, indexed by the 3-bit phase
//     - next_index() : phase index advance for one half- or full-step
// -----------------------------------------------------------------------------
package stepper_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Coil patterns for phase index 0..7 (entry [0] is the rightmost nibble).
    // Even indices energise one coil (wave drive), odd indices energise two.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001,   // 7
        4'b0001,   // 6
        4'b0101,   // 5
        4'b0100,   // 4
        4'b0110,   // 3
        4'b0010,   // 2
        4'b1010,   // 1
        4'b1000    // 0
    };

    // Advance the phase index by one step. Half-step moves one entry, full-step
    // moves two so index parity (wave vs. two-coil drive) is preserved. The
    // 3-bit result wraps modulo 8 naturally.
    function automatic logic [2:0] next_index(input logic [2:0] idx,
                                              input logic       dir,
                                              input logic       half);
        logic [2:0] stride;
        stride = half ? 3'd1 : 3'd2;
        return dir ? (idx + stride) : (idx - stride);
    endfunction

endpackage

// File: rtl/stepper_seq_ctrl_step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
//   Down-counter that paces steps. A period of 0 is treated as 1.
//   After a load, tick is high during the P-th cycle following the load edge,
//   so the consumer sees its step edge exactly P cycles after the load. The
//   counter then reloads itself and repeats every P cycles.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   load    in   restart the period (sampled on the rising edge)
//   period  in   PER_W  cycles per tick; used on load and on every reload
//   tick    out  high for one cycle out of every P
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int PER_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [PER_W-1:0] count;
    logic [PER_W-1:0] reload;

    // NOTE: every combinational output is assigned on every path through the
    // block; a path that leaves one unassigned infers a latch.
    always_comb begin
        reload = (period == '0) ? '0 : (period - PER_W'(1));
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load || (count == '0)) begin
            count <= reload;
        end else begin
            count <= count - PER_W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/stepper_seq_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_seq_ctrl
//   Executes commanded stepper moves for one wheel: step count, direction,
//   half/full-step mode and step period. Tracks the coil phase index and a
//   signed cumulative half-step position, and drives the coil pattern.
//
// Parameters:
//   CNT_W    width of the step count
//   PER_W    width of the step period (clock cycles)
//   POS_W    width of the signed position counter
//   HOLD_EN  1: hold the last pattern while idle; 0: de-energise when idle
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cmd_valid    in   command offered
//   cmd_ready    out  high only while idle
//   cmd_steps    in   steps to take (0 = accepted, done pulse, no motion)
//   cmd_dir      in   1 forward (index +, position +), 0 reverse
//   cmd_half     in   1 half-step (index +-1), 0 full-step (index +-2)
//   cmd_period   in   clock cycles per step (0 treated as 1)
//   abort        in   end the current move after this edge
//   pulseout     out  4-bit coil pattern
//   busy         out  high while running a move
//   done         out  one-cycle pulse when a move (or zero-step command) ends
//   aborted      out  last move ended by abort; cleared on next accept
//   position     out  signed cumulative half-step position
// -----------------------------------------------------------------------------
module stepper_seq_ctrl
    import stepper_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int PER_W   = 20,
    parameter int POS_W   = 24,
    parameter bit HOLD_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic                    cmd_dir,
    input  logic                    cmd_half,
    input  logic [PER_W-1:0]        cmd_period,
    input  logic                    abort,
    output logic [3:0]              pulseout,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic signed [POS_W-1:0] position
);

    state_t                  state;
    logic [CNT_W-1:0]        remaining;
    logic [2:0]              index;
    logic                    dir_q;
    logic                    half_q;
    logic [PER_W-1:0]        period_q;

    logic                    accept;
    logic                    timer_load;
    logic [PER_W-1:0]        timer_period;
    logic                    tick;
    logic                    step;
    logic                    last_step;
    logic                    move_end;
    logic [2:0]              index_next;
    logic signed [POS_W-1:0] stride;

    always_comb begin
        accept     = cmd_valid && cmd_ready;
        timer_load = accept && (cmd_steps != '0);
        // The period register is not written until the accept edge, so the
        // timer must take the command's period directly when it is loaded.
        timer_period = accept ? cmd_period : period_q;
        step       = (state == RUN) && tick;
        last_step  = step && (remaining == CNT_W'(1));
        // An abort coinciding with a step still lets that step happen; the
        // step branch below runs before the end-of-move branch.
        move_end   = (state == RUN) && (last_step || abort);
        index_next = next_index(index, dir_q, half_q);
        stride     = half_q ? POS_W'(1) : POS_W'(2);
    end

    step_timer #(
        .PER_W (PER_W)
    ) u_step_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .period (timer_period),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            index     <= 3'd0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            period_q  <= '0;
            position  <= '0;
            pulseout  <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        aborted <= 1'b0;
                        if (cmd_steps == '0) begin
                            // Zero-step command: acknowledge without motion.
                            done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            remaining <= cmd_steps;
                            dir_q     <= cmd_dir;
                            half_q    <= cmd_half;
                            period_q  <= cmd_period;
                            // Energise the current detent before the first step.
                            pulseout  <= PHASE_TABLE[index];
                        end
                    end
                end

                RUN: begin
                    if (step) begin
                        index     <= index_next;
                        position  <= dir_q ? (position + stride) : (position - stride);
                        remaining <= remaining - CNT_W'(1);
                        pulseout  <= PHASE_TABLE[index_next];
                    end
                    if (move_end) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        done      <= 1'b1;
                        aborted   <= abort;
                        // Without holding torque, coils drop on the edge that
                        // enters idle, overriding any final step pattern.
                        if (!HOLD_EN) begin
                            pulseout <= 4'b0000;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepper_seq_ctrl
//   Drives two sequencer instances (HOLD_EN=1 and HOLD_EN=0) with the same
//   command stream. For each command the driver derives, from the move rules,
//   the cycle-stamped sequence of visible output changes and queues it; a
//   monitor pops an entry whenever an instance's outputs change (or done is
//   high) and compares.
// -----------------------------------------------------------------------------
module tb_stepper_seq_ctrl;

    localparam int CNT_W = 16;
    localparam int PER_W = 20;
    localparam int POS_W = 24;

    localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                                       4'b0100, 4'b0101, 4'b0001, 4'b1001};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic             cmd_half;
    logic [PER_W-1:0] cmd_period;
    logic             abort;

    logic             rdy_h, busy_h, done_h, abrt_h;
    logic [3:0]       pulse_h;
    logic [POS_W-1:0] pos_h;
    logic             rdy_f, busy_f, done_f, abrt_f;
    logic [3:0]       pulse_f;
    logic [POS_W-1:0] pos_f;

    stepper_seq_ctrl #(.CNT_W(CNT_W), .PER_W(PER_W), .POS_W(POS_W), .HOLD_EN(1'b1)) dut_hold (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_h),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
        .cmd_period(cmd_period), .abort(abort), .pulseout(pulse_h), .busy(busy_h),
        .done(done_h), .aborted(abrt_h), .position(pos_h));

    stepper_seq_ctrl #(.CNT_W(CNT_W), .PER_W(PER_W), .POS_W(POS_W), .HOLD_EN(1'b0)) dut_free (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_f),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
        .cmd_period(cmd_period), .abort(abort), .pulseout(pulse_f), .busy(busy_f),
        .done(done_f), .aborted(abrt_f), .position(pos_f));

    always #5 clk = ~clk;

    // Number of rising edges so far; stable when read on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0]       pulse;
        logic [POS_W-1:0] pos;
        logic             busy;
        logic             done;
        logic             aborted;
        logic             ready;
    } snap_t;

    typedef struct {
        int    cycle;
        snap_t s;
    } rec_t;

    rec_t  q_h[$];
    rec_t  q_f[$];
    int    tests = 0;
    int    fails = 0;
    bit    mon_en = 1'b0;
    snap_t prev_h, prev_f;

    // Reference model state.
    int         m_idx = 0;
    int         m_pos = 0;
    int         prev_end = -10;
    logic [3:0] m_pulse_h = 4'b0000;
    logic [3:0] m_pulse_f = 4'b0000;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic snap_t sample(input int i);
        snap_t s;
        if (i == 0) begin
            s.pulse = pulse_h; s.pos = pos_h; s.busy = busy_h;
            s.done = done_h; s.aborted = abrt_h; s.ready = rdy_h;
        end else begin
            s.pulse = pulse_f; s.pos = pos_f; s.busy = busy_f;
            s.done = done_f; s.aborted = abrt_f; s.ready = rdy_f;
        end
        return s;
    endfunction

    task automatic check_event(input int i, input snap_t s);
        rec_t  e;
        string tag;
        bit    empty;
        tag   = (i == 0) ? "hold" : "free";
        empty = (i == 0) ? (q_h.size() == 0) : (q_f.size() == 0);
        tests++;
        if (empty) begin
            fails++;
            $display("FAIL event %s @%0d: unexpected change pulse=%b pos=%0d busy=%b done=%b",
                     tag, cyc, s.pulse, s.pos, s.busy, s.done);
            return;
        end
        e = (i == 0) ? q_h.pop_front() : q_f.pop_front();
        if (e.cycle != cyc || e.s != s) begin
            fails++;
            $display("FAIL event %s @%0d: got pulse=%b pos=%0d busy=%b done=%b abrt=%b rdy=%b; expected @%0d pulse=%b pos=%0d busy=%b done=%b abrt=%b rdy=%b",
                     tag, cyc, s.pulse, s.pos, s.busy, s.done, s.aborted, s.ready,
                     e.cycle, e.s.pulse, e.s.pos, e.s.busy, e.s.done, e.s.aborted, e.s.ready);
        end
    endtask

    // Monitor: an instance "presents" an output whenever anything visible
    // changes, or while done is high.
    always @(negedge clk) begin
        snap_t sh, sf;
        sh = sample(0);
        sf = sample(1);
        if (mon_en) begin
            if (sh != prev_h || sh.done) check_event(0, sh);
            if (sf != prev_f || sf.done) check_event(1, sf);
        end
        prev_h = sh;
        prev_f = sf;
    end

    task automatic push(input int c, input logic [3:0] ph, input logic [3:0] pf,
                        input logic b, input logic d, input logic a, input logic r);
        rec_t e;
        e.cycle     = c;
        e.s.pos     = POS_W'(m_pos);
        e.s.busy    = b;
        e.s.done    = d;
        e.s.aborted = a;
        e.s.ready   = r;
        e.s.pulse   = ph;
        q_h.push_back(e);
        e.s.pulse   = pf;
        q_f.push_back(e);
    endtask

    // Issue one command at the next rising edge and run it to completion.
    // abort_at: if nonzero, abort is sampled on the edge that many cycles after
    // the accept edge (always before the natural end). gap: idle cycles after
    // the end edge (0 = next command may be offered in the done cycle).
    // cut: if nonzero, return that many cycles after accept (move unfinished).
    task automatic issue(input int steps, input bit dir, input bit half, input int per,
                         input int abort_at, input int gap, input int cut);
        int p, c_a, end_c, n_taken, s, c;
        bit ab;
        p   = (per == 0) ? 1 : per;
        c_a = cyc + 1;
        s   = half ? 1 : 2;
        if (!dir) s = -s;

        // The previous move's done-drop entry coincides with this accept edge.
        if (c_a == prev_end + 1 && q_h.size() > 0) begin
            q_h.delete(q_h.size() - 1);
            q_f.delete(q_f.size() - 1);
        end

        if (steps == 0) begin
            end_c = c_a;
            push(c_a,     m_pulse_h, m_pulse_f, 1'b0, 1'b1, 1'b0, 1'b1);
            push(c_a + 1, m_pulse_h, m_pulse_f, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            push(c_a, TBL[m_idx], TBL[m_idx], 1'b1, 1'b0, 1'b0, 1'b0);
            if (abort_at > 0) begin
                n_taken = abort_at / p;
                end_c   = c_a + abort_at;
                ab      = 1'b1;
            end else begin
                n_taken = steps;
                end_c   = c_a + steps * p;
                ab      = 1'b0;
            end
            for (int k = 1; k <= n_taken; k++) begin
                m_idx = (m_idx + 8 + s) % 8;
                m_pos = m_pos + s;
                c     = c_a + k * p;
                if (c == end_c) push(c, TBL[m_idx], 4'b0000, 1'b0, 1'b1, ab, 1'b1);
                else            push(c, TBL[m_idx], TBL[m_idx], 1'b1, 1'b0, 1'b0, 1'b0);
            end
            if (n_taken * p != end_c - c_a)
                push(end_c, TBL[m_idx], 4'b0000, 1'b0, 1'b1, ab, 1'b1);
            push(end_c + 1, TBL[m_idx], 4'b0000, 1'b0, 1'b0, ab, 1'b1);
            m_pulse_h = TBL[m_idx];
            m_pulse_f = 4'b0000;
        end
        prev_end = end_c;

        cmd_valid  = 1'b1;
        cmd_steps  = CNT_W'(steps);
        cmd_dir    = dir;
        cmd_half   = half;
        cmd_period = PER_W'(per);
        abort      = 1'b0;
        @(negedge clk);

        // While running, command inputs carry junk that must be ignored.
        while (cyc < end_c) begin
            if (cut > 0 && cyc >= c_a + cut) return;
            cmd_valid  = 1'($urandom);
            cmd_steps  = CNT_W'($urandom);
            cmd_dir    = 1'($urandom);
            cmd_half   = 1'($urandom);
            cmd_period = PER_W'($urandom);
            abort      = (abort_at != 0) && (cyc + 1 == c_a + abort_at);
            @(negedge clk);
        end
        if (gap == 0) return;
        cmd_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            abort = 1'($urandom);   // abort while idle is ignored
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pulse_hold"}, pulse_h, 0);
        check({tag, "_pos_hold"},   pos_h,   0);
        check({tag, "_busy_hold"},  busy_h,  0);
        check({tag, "_done_hold"},  done_h,  0);
        check({tag, "_abrt_hold"},  abrt_h,  0);
        check({tag, "_rdy_hold"},   rdy_h,   1);
        check({tag, "_pulse_free"}, pulse_f, 0);
        check({tag, "_pos_free"},   pos_f,   0);
        check({tag, "_rdy_free"},   rdy_f,   1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps, per, p, ab_at, gap;
        cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; cmd_half = 1'b0;
        cmd_period = '0; abort = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Half-step forward through the wrap: index 0 -> 10 mod 8 = 2.
        issue(10, 1'b1, 1'b1, 4, 0, 2, 0);
        check("wrap_pattern",    pulse_h, 4'b0010);
        check("wrap_position",   pos_h,   10);
        check("wrap_free_coils", pulse_f, 4'b0000);

        // Move to odd index 1, then full-step reverse: 7, 5, 3.
        issue(1, 1'b0, 1'b1, 3, 0, 1, 0);
        issue(3, 1'b0, 1'b0, 1, 0, 2, 0);
        check("fullrev_pattern",  pulse_h, 4'b0110);
        check("fullrev_position", pos_h,   3);

        // Abort on the 10th step edge of a 100-step move, period 2.
        issue(100, 1'b1, 1'b1, 2, 20, 0, 0);
        check("abort_position", pos_h,  13);
        check("abort_flag",     abrt_h, 1);
        check("abort_ready",    rdy_h,  1);

        // Zero-step command offered in the done cycle.
        issue(0, 1'b1, 1'b1, 7, 0, 2, 0);
        check("zero_keeps_pattern",  pulse_h, 4'b0101);
        check("zero_clears_aborted", abrt_h,  0);

        // Period 0 behaves as period 1.
        issue(3, 1'b1, 1'b0, 0, 0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            steps = $urandom_range(0, 12);
            per   = $urandom_range(0, 5);
            p     = (per == 0) ? 1 : per;
            ab_at = 0;
            if (steps * p > 1 && $urandom_range(0, 3) == 0)
                ab_at = $urandom_range(1, steps * p - 1);
            gap = (n == 39) ? 1 : $urandom_range(0, 3);
            issue(steps, 1'($urandom), 1'($urandom), per, ab_at, gap, 0);
        end

        // Asynchronous reset in the middle of a move.
        issue(50, 1'b1, 1'b1, 3, 0, 0, 10);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        mon_en    = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        q_h.delete();
        q_f.delete();
        m_idx = 0; m_pos = 0; m_pulse_h = 4'b0000; m_pulse_f = 4'b0000; prev_end = -10;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        issue(1, 1'b1, 1'b1, 2, 0, 2, 0);
        check("post_reset_pattern",  pulse_h, 4'b1010);
        check("post_reset_position", pos_h,   1);

        repeat (4) @(negedge clk);
        check("hold_queue_drained", q_h.size(), 0);
        check("free_queue_drained", q_f.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
